// File: rtl/delay_tap_pkg.sv
// rtl/delay_tap_pkg.sv - shared constants, default tap delays and circular address helper for delay_tap_scheduler
package delay_tap_pkg;

    localparam int MAX_ADDR_DEF = 90000;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    // Tables wider than eight taps repeat the eight-entry default pattern
    function automatic logic [31:0] default_delay(input int unsigned i);
        case (i % 8)
            0:       return 32'd21000;
            1:       return 32'd32000;
            2:       return 32'd47000;
            3:       return 32'd63000;
            4:       return 32'd54000;
            5:       return 32'd8800;
            6:       return 32'd38500;
            default: return 32'd69500;
        endcase
    endfunction

    function automatic logic [31:0] circ_sub(input logic [31:0] base, input logic [31:0] delta,
                                             input logic [31:0] max_addr);
        if (base >= delta) return base - delta;
        else               return base + max_addr - delta;
    endfunction

endpackage

// File: rtl/delay_tap_scheduler_table.sv
// rtl/delay_tap_scheduler_table.sv - delay_tap_table: shadow/active tap tables with clamping and deferred commit (TAP_GAIN_EN adds per-tap shift)
module delay_tap_table
    import delay_tap_pkg::*;
#(
    parameter int ADDR_W   = 17,
    parameter int MAX_ADDR = MAX_ADDR_DEF,
    parameter int NUM_TAPS = 8,
    parameter int IDX_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              idle,
    input  logic              sample_valid,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_delay,
    input  logic              cfg_commit,
    input  logic [IDX_W-1:0]  rd_idx,
`ifdef TAP_GAIN_EN
    input  logic [2:0]        cfg_shift,
    output logic [2:0]        rd_shift,
`endif
    output logic [ADDR_W-1:0] rd_delay
);

    logic [ADDR_W-1:0] shadow_d [NUM_TAPS];
    logic [ADDR_W-1:0] active_d [NUM_TAPS];
    logic [ADDR_W-1:0] shadow_d_next [NUM_TAPS];
    logic              pending;
    logic              copy_now;
    logic              load;

    function automatic logic [ADDR_W-1:0] clamp(input logic [31:0] v);
        if (v >= 32'(MAX_ADDR)) return ADDR_W'(MAX_ADDR - 1);
        else                    return v[ADDR_W-1:0];
    endfunction

    assign copy_now = cfg_commit && idle && !sample_valid;
    // A pending commit lands on the cycle the next sample is accepted, before its reads
    assign load     = copy_now || (idle && sample_valid && pending);
    assign rd_delay = active_d[rd_idx];

    always_comb begin
        shadow_d_next = shadow_d;
        if (cfg_we) shadow_d_next[cfg_idx] = clamp(32'(cfg_delay));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                shadow_d[i] <= clamp(default_delay(i));
                active_d[i] <= clamp(default_delay(i));
            end
            pending <= 1'b0;
        end else begin
            shadow_d <= shadow_d_next;
            if (load) active_d <= shadow_d_next;
            if (cfg_commit && !copy_now) pending <= 1'b1;
            else if (idle && sample_valid) pending <= 1'b0;
        end
    end

`ifdef TAP_GAIN_EN
    logic [2:0] shadow_s [NUM_TAPS];
    logic [2:0] active_s [NUM_TAPS];
    logic [2:0] shadow_s_next [NUM_TAPS];

    assign rd_shift = active_s[rd_idx];

    always_comb begin
        shadow_s_next = shadow_s;
        if (cfg_we) shadow_s_next[cfg_idx] = cfg_shift;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                shadow_s[i] <= 3'd0;
                active_s[i] <= 3'd0;
            end
        end else begin
            shadow_s <= shadow_s_next;
            if (load) active_s <= shadow_s_next;
        end
    end
`endif

endmodule

// File: rtl/delay_tap_scheduler.sv
// rtl/delay_tap_scheduler.sv - per-sample write then NUM_TAPS tap reads of a delayline BRAM; macro TAP_GAIN_EN adds per-tap shift
module delay_tap_scheduler
    import delay_tap_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 17,
    parameter int MAX_ADDR = MAX_ADDR_DEF,
    parameter int NUM_TAPS = 8,
    parameter int IDX_W    = 3
) (
    input  logic              clk_50m,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_in,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              tap_valid,
    output logic [IDX_W-1:0]  tap_idx,
    output logic [DATA_W-1:0] tap_data,
    output logic              frame_done,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_delay,
`ifdef TAP_GAIN_EN
    input  logic [2:0]        cfg_shift,
`endif
    input  logic              cfg_commit,
    output logic              overrun
);

    localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(NUM_TAPS - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] wptr;
    logic              p1_valid, p2_valid;
    logic [IDX_W-1:0]  p1_idx, p2_idx;
    logic [IDX_W-1:0]  lookup_idx;
    logic [ADDR_W-1:0] rd_delay;
    logic [31:0]       tap_addr_full;
    logic [ADDR_W-1:0] tap_addr;
    logic [DATA_W-1:0] tap_value;

    // p1 tracks the tap whose address is on the bus; p2 the tap whose data is on mem_dout
    assign lookup_idx    = (state == S_READ) ? p1_idx + IDX_W'(1) : '0;
    assign tap_addr_full = circ_sub(32'(wptr), 32'(rd_delay), 32'(MAX_ADDR));
    assign tap_addr      = tap_addr_full[ADDR_W-1:0];

    delay_tap_table #(
        .ADDR_W   (ADDR_W),
        .MAX_ADDR (MAX_ADDR),
        .NUM_TAPS (NUM_TAPS),
        .IDX_W    (IDX_W)
    ) u_table (
        .clk          (clk_50m),
        .rst          (rst),
        .idle         (state == S_IDLE),
        .sample_valid (sample_valid),
        .cfg_we       (cfg_we),
        .cfg_idx      (cfg_idx),
        .cfg_delay    (cfg_delay),
        .cfg_commit   (cfg_commit),
        .rd_idx       (lookup_idx),
`ifdef TAP_GAIN_EN
        .cfg_shift    (cfg_shift),
        .rd_shift     (rd_shift),
`endif
        .rd_delay     (rd_delay)
    );

`ifdef TAP_GAIN_EN
    logic [2:0] rd_shift, p1_shift, p2_shift;

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            p1_shift <= 3'd0;
            p2_shift <= 3'd0;
        end else begin
            p1_shift <= rd_shift;
            p2_shift <= p1_shift;
        end
    end

    assign tap_value = $signed(mem_dout) >>> p2_shift;
`else
    assign tap_value = mem_dout;
`endif

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            wptr       <= '0;
            busy       <= 1'b0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_din    <= '0;
            p1_valid   <= 1'b0;
            p1_idx     <= '0;
            p2_valid   <= 1'b0;
            p2_idx     <= '0;
            tap_valid  <= 1'b0;
            tap_idx    <= '0;
            tap_data   <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            mem_we     <= 1'b0;
            p2_valid   <= p1_valid;
            p2_idx     <= p1_idx;
            tap_valid  <= p2_valid;
            tap_idx    <= p2_idx;
            tap_data   <= tap_value;
            frame_done <= p2_valid && (p2_idx == LAST_TAP);
            if (sample_valid && state != S_IDLE) overrun <= 1'b1;
            case (state)
                S_IDLE: if (sample_valid) begin
                    state    <= S_WRITE;
                    busy     <= 1'b1;
                    mem_we   <= 1'b1;
                    mem_addr <= wptr;
                    mem_din  <= sample_in;
                end
                S_WRITE: begin
                    state    <= S_READ;
                    mem_addr <= tap_addr;
                    p1_valid <= 1'b1;
                    p1_idx   <= '0;
                end
                S_READ: if (p1_idx == LAST_TAP) begin
                    state    <= S_DRAIN;
                    p1_valid <= 1'b0;
                end else begin
                    mem_addr <= tap_addr;
                    p1_idx   <= p1_idx + IDX_W'(1);
                end
                S_DRAIN: if (frame_done) begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    wptr  <= (32'(wptr) == 32'(MAX_ADDR - 1)) ? '0 : wptr + ADDR_W'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
